conv_loop_counter: RTL and testbench

Parametrised output-position loop counter for the convolution layers. It generalises the per-layer x/y/channel counters into a single three-level nest: column x, row y and channel group u, with configurable extents and stride, a start/busy/done handshake, and stall/flush control. It sits between the layer controller and the address generators; it is driven by the inner kernel counter's wrap pulse and feeds the feature-map and weight address logic.

---
 rtl/conv_loop_counter.sv | 139 +++++++++++++
 tb/tb_conv_loop_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/conv_loop_counter.sv
// conv_loop_counter: three-level column/row/channel-group loop nest with start/busy/done handshake.
// Define CONV_LOOP_STRIDE_EN to replace the constant STRIDE with a runtime stride port.
module conv_loop_counter #(
  parameter int unsigned X_LAST = 14,
  parameter int unsigned Y_LAST = 14,
  parameter int unsigned U_LAST = 4,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned XW     = 5,
  parameter int unsigned YW     = 5,
  parameter int unsigned UW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          adv,
  input  logic          stall,
  input  logic          flush,
`ifdef CONV_LOOP_STRIDE_EN
  input  logic [1:0]    stride,
`endif
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [UW-1:0] u,
  output logic          x_wrap,
  output logic          y_wrap,
  output logic          busy,
  output logic          done
);

  localparam int unsigned SW = XW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [UW-1:0] u_q, u_d;
  logic          done_q, done_d;

  logic [SW-1:0] step;
  logic [SW-1:0] x_sum;
  logic          eff_adv;
  logic          x_over;
  logic          y_last;
  logic          u_last;
  logic          x_wrap_cond;

  // Column step; a runtime stride of 0 behaves as 1.
`ifdef CONV_LOOP_STRIDE_EN
  assign step = (stride == 2'd0) ? SW'(1) : SW'(stride);
`else
  assign step = SW'(STRIDE);
`endif

  // x + s is formed one bit wider than x so the overflow test cannot alias.
  assign eff_adv     = adv & (state_q == ST_RUN) & ~stall & ~flush;
  assign x_sum       = {1'b0, x_q} + step;
  assign x_over      = x_sum > SW'(X_LAST);
  assign y_last      = (y_q == YW'(Y_LAST));
  assign u_last      = (u_q == UW'(U_LAST));
  assign x_wrap_cond = eff_adv & x_over;

  assign x_wrap = x_wrap_cond | flush;
  assign y_wrap = x_wrap_cond & y_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      u_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      u_q     <= u_d;
      done_q  <= done_d;
    end
  end

  // Next state: flush beats stall, stall beats advance.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    u_d     = u_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
      u_d     = '0;
    end else if (!stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (eff_adv) begin
            if (!x_over) begin
              x_d = x_sum[XW-1:0];
            end else begin
              x_d = '0;
              if (!y_last) begin
                y_d = y_q + YW'(1);
              end else begin
                y_d = '0;
                if (!u_last) begin
                  u_d = u_q + UW'(1);
                end else begin
                  u_d     = '0;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign u    = u_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_conv_loop_counter.sv
// Scoreboard bench for conv_loop_counter: driver queues expected outputs, negedge monitor compares.
module tb_conv_loop_counter;

  localparam int unsigned XL = 14;
  localparam int unsigned YL = 2;
  localparam int unsigned UL = 4;
  localparam int unsigned XW = 5;
  localparam int unsigned YW = 5;
  localparam int unsigned UW = 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          adv   = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
`ifdef CONV_LOOP_STRIDE_EN
  logic [1:0]    stride = 2'd1;
`endif
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [UW-1:0] u;
  logic          x_wrap, y_wrap, busy, done;

  typedef struct {
    string tag;
    int    x, y, u;
    bit    busy, done, xw, yw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   yw_cnt = 0;
  int   done_cnt = 0;
  bit   cnt_en = 1'b0;

  conv_loop_counter #(
    .X_LAST(XL), .Y_LAST(YL), .U_LAST(UL), .STRIDE(1),
    .XW(XW), .YW(YW), .UW(UW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .adv(adv), .stall(stall), .flush(flush),
`ifdef CONV_LOOP_STRIDE_EN
    .stride(stride),
`endif
    .x(x), .y(y), .u(u), .x_wrap(x_wrap), .y_wrap(y_wrap), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Monitor: outputs are compared mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (int'(x) != mon_e.x || int'(y) != mon_e.y || int'(u) != mon_e.u ||
          busy !== mon_e.busy || done !== mon_e.done ||
          x_wrap !== mon_e.xw || y_wrap !== mon_e.yw) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d u=%0d busy=%b done=%b xw=%b yw=%b, expected x=%0d y=%0d u=%0d busy=%b done=%b xw=%b yw=%b",
                 mon_e.tag, x, y, u, busy, done, x_wrap, y_wrap,
                 mon_e.x, mon_e.y, mon_e.u, mon_e.busy, mon_e.done, mon_e.xw, mon_e.yw);
      end
    end
    if (cnt_en) begin
      if (y_wrap === 1'b1) yw_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic drive(input bit r, input bit st, input bit a, input bit sl, input bit fl);
    @(posedge clk);
    #1;
    rst   = r;
    start = st;
    adv   = a;
    stall = sl;
    flush = fl;
  endtask

  task automatic expect_o(input string tag, input int ex, input int ey, input int eu,
                          input bit eb, input bit ed, input bit exw, input bit eyw);
    exp_t e;
    e = '{tag, ex, ey, eu, eb, ed, exw, eyw};
    sb.push_back(e);
  endtask

  // Advance pulses k0..k0+n-1 of a pass; pulse k sees position k in row-major order.
  task automatic adv_seq(input string tag, input int k0, input int n);
    int px, py, pu;
    for (int k = k0; k < k0 + n; k++) begin
      px = k % (XL + 1);
      py = (k / (XL + 1)) % (YL + 1);
      pu = k / ((XL + 1) * (YL + 1));
      drive(0, 0, 1, 0, 0);
      expect_o(tag, px, py, pu, 1, 0, px == XL, (px == XL) && (py == YL));
    end
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);  expect_o("reset", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);  expect_o("start_adv_idle", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("start_taken", 0, 0, 0, 1, 0, 0, 0);
    adv_seq("row0", 0, 15);
    drive(0, 0, 0, 0, 0);  expect_o("row_wrap", 0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);  expect_o("start_in_run", 0, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("start_ignored", 0, 1, 0, 1, 0, 0, 0);
    adv_seq("row1", 15, 7);
    repeat (3) begin
      drive(0, 0, 1, 1, 0); expect_o("stall_hold", 7, 1, 0, 1, 0, 0, 0);
    end
    drive(0, 0, 1, 1, 1);  expect_o("flush_stall", 7, 1, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0);  expect_o("after_flush_stall", 0, 0, 0, 0, 0, 0, 0);

    drive(0, 1, 0, 0, 0);  expect_o("idle_start", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("run2", 0, 0, 0, 1, 0, 0, 0);
    adv_seq("to_flush", 0, 114);
    drive(0, 0, 1, 0, 1);  expect_o("flush", 9, 1, 2, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0);  expect_o("post_flush", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("post_flush_nodone", 0, 0, 0, 0, 0, 0, 0);

    drive(0, 1, 0, 0, 0);
    yw_cnt = 0; done_cnt = 0; cnt_en = 1'b1;
    expect_o("pass_start", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("pass_run", 0, 0, 0, 1, 0, 0, 0);
    adv_seq("pass", 0, 225);
    drive(0, 1, 0, 0, 0);  expect_o("pass_done", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("restart", 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("restart_hold", 0, 0, 0, 1, 0, 0, 0);
    cnt_en = 1'b0;
    chk("y_wrap_count", yw_cnt, 5);
    chk("done_count", done_cnt, 1);

    adv_seq("pre_rst", 0, 5);
    drive(1, 0, 1, 0, 0);  expect_o("rst_cycle", 5, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("after_rst", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  expect_o("after_rst_nodone", 0, 0, 0, 0, 0, 0, 0);

`ifdef CONV_LOOP_STRIDE_EN
    drive(0, 1, 0, 0, 0);  expect_o("stride_start", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);  stride = 2'd2; expect_o("stride_run", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 0); expect_o("stride2", 2 * i, 0, 0, 1, 0, i == 7, 0);
    end
    drive(0, 0, 1, 0, 0);  stride = 2'd0; expect_o("stride0_a", 0, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);  expect_o("stride0_b", 1, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);  expect_o("stride_flush", 2, 1, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0);  stride = 2'd1; expect_o("stride_after", 0, 0, 0, 0, 0, 0, 0);
`endif

    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
